// File: rtl/hwterm_pkg.sv
// Shared definitions for the terminal transmit path: FSM encoding and
// the default bit period.
package hwterm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Last value of the 16-bit baud counter for a given bit period.
    function automatic logic [15:0] baud_last(input int clks_per_bit);
        return 16'(clks_per_bit - 1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte strobe in, serial line and status out, for the UART transmitter.
interface uart_tx_if;
    logic [7:0] i_byte;
    logic       i_byte_v;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    modport master (
        output i_byte, i_byte_v,
        input  o_tx, o_busy, o_full, o_overflow
    );

    modport slave (
        input  i_byte, i_byte_v,
        output o_tx, o_busy, o_full, o_overflow
    );
endinterface

// File: rtl/uart_tx_byte_fifo.sv
// Small byte FIFO with one extra pointer bit to tell full from empty.
// Read data is the current head, available combinationally.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    // Pointer update; wraps modulo 2*DEPTH through natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, fed by a byte FIFO with no back-pressure.
// The line output is registered from the current state, so a byte pushed
// into an idle block shows its start bit two edges after the push.
module uart_tx
    import hwterm_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam logic [15:0] BAUD_LAST = baud_last(CLKS_PER_BIT);

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        ovf_q;

    logic        fifo_empty, fifo_full;
    logic        pop, push, drop;
    logic [7:0]  fifo_rdata;
    logic        bit_end;

    // A pop in the same cycle frees a slot, so a strobe while full still lands.
    assign push = bus.i_byte_v & (~fifo_full | pop);
    assign drop = bus.i_byte_v & fifo_full & ~pop;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.i_byte),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bit_end = (cnt_q == BAUD_LAST);

    // Next-state, baud/bit counting, FIFO pop and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset forces the line high and abandons any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovf_q   <= drop;
        end
    end

    // Shift register holds the frame payload; only meaningful outside IDLE.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign bus.o_tx       = tx_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_full     = fifo_full;
    assign bus.o_busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst;
    uart_tx_if bus();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         rx_frame_err = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in time order, index 0 = start bit
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        bus.i_byte   = b;
        bus.i_byte_v = 1'b1;
        tick();
        bus.i_byte_v = 1'b0;
    endtask

    // Samples the 40 line cycles of one frame; first sample is two edges after the push.
    task automatic check_frame(input logic [9:0] fb, input bit last);
        for (int s = 0; s < FRAME; s++) begin
            tick();
            chk("frame_bit", 32'(bus.o_tx), 32'(fb[s / CPB]));
            if (s == FRAME - 2) chk("busy_in_frame", 32'(bus.o_busy), 32'd1);
            if (s == FRAME - 1 && last) chk("busy_after_frame", 32'(bus.o_busy), 32'd0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.o_busy && n < 1000) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.o_busy), 32'd0);
        repeat (4) tick();
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    // Line receiver: mid-bit sampling after a falling start edge.
    initial begin
        logic [7:0] b;
        forever begin
            tick();
            if (rst && bus.o_tx == 1'b0) begin
                repeat (CPB / 2) tick();
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    b[i] = bus.o_tx;
                end
                repeat (CPB) tick();
                if (bus.o_tx !== 1'b1) rx_frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   m_cnt, m_rem, m_drop, obs_ovf;
        bit   pop_m, acc, v;
        logic [7:0] b;
        int   rates[3];
        int   size_before;
        int   low_seen;

        vecs[0] = '{data: 8'h41, frame: 10'h282};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'hA5, frame: 10'h34A};
        rates   = '{10, 40, 90};

        rst = 1'b1;
        bus.i_byte   = 8'h00;
        bus.i_byte_v = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_tx",   32'(bus.o_tx),       32'd1);
        chk("rst_busy", 32'(bus.o_busy),     32'd0);
        chk("rst_full", 32'(bus.o_full),     32'd0);
        chk("rst_ovf",  32'(bus.o_overflow), 32'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        tick();

        // Single frames from the table
        rx_q.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            push_one(vecs[k].data);
            exp_q.push_back(vecs[k].data);
            tick();
            chk("latency_still_high", 32'(bus.o_tx), 32'd1);
            chk("busy_after_push", 32'(bus.o_busy), 32'd1);
            check_frame(vecs[k].frame, 1'b1);
            repeat (3) tick();
        end
        check_rx("table_rx");

        // Back-to-back frames: second start bit follows first stop bit directly
        push_one(8'h6A);
        push_one(8'h6B);
        check_frame(10'h2D4, 1'b0);
        check_frame(10'h2D6, 1'b1);
        wait_idle("b2b_idle");

        // Six strobes while idle: one popped, four queued, sixth dropped
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            bus.i_byte   = 8'h10 + 8'(i);
            bus.i_byte_v = 1'b1;
            tick();
            if (i < 5) exp_q.push_back(8'h10 + 8'(i));
            if (i == 3) chk("not_full_yet", 32'(bus.o_full), 32'd0);
            if (i == 4) begin
                chk("full_after_5", 32'(bus.o_full), 32'd1);
                chk("no_ovf_yet", 32'(bus.o_overflow), 32'd0);
            end
            if (i == 5) chk("ovf_pulse", 32'(bus.o_overflow), 32'd1);
        end
        bus.i_byte_v = 1'b0;
        tick();
        chk("ovf_one_cycle", 32'(bus.o_overflow), 32'd0);
        chk("still_full", 32'(bus.o_full), 32'd1);
        wait_idle("ovf_idle");
        check_rx("ovf_rx");

        // Push while full, in the same cycle as the stop-end pop
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_one(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        repeat (FRAME - 4) tick();
        chk("full_before_pop", 32'(bus.o_full), 32'd1);
        push_one(8'h25);
        exp_q.push_back(8'h25);
        chk("no_ovf_on_pop_push", 32'(bus.o_overflow), 32'd0);
        chk("full_kept", 32'(bus.o_full), 32'd1);
        tick();
        chk("no_ovf_later", 32'(bus.o_overflow), 32'd0);
        wait_idle("popfull_idle");
        check_rx("popfull_rx");

        // Reset during bit 3 of a frame with two bytes queued
        push_one(8'h00);
        push_one(8'h11);
        push_one(8'h22);
        repeat (16) tick();
        chk("bit3_low", 32'(bus.o_tx), 32'd0);
        chk("bit3_busy", 32'(bus.o_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_tx_high", 32'(bus.o_tx), 32'd1);
        chk("async_busy_low", 32'(bus.o_busy), 32'd0);
        chk("async_full_low", 32'(bus.o_full), 32'd0);
        #2 rst = 1'b1;
        repeat (60) tick();
        size_before = rx_q.size();
        low_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) low_seen++;
        end
        chk("quiet_after_reset", low_seen, 0);
        chk("no_rx_after_reset", rx_q.size(), size_before);

        // First push right after reset release is accepted
        rx_q.delete();
        exp_q.delete();
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        bus.i_byte   = 8'h5A;
        bus.i_byte_v = 1'b1;
        tick();
        bus.i_byte_v = 1'b0;
        chk("push_after_release", 32'(bus.o_busy), 32'd1);
        exp_q.push_back(8'h5A);
        wait_idle("release_idle");
        check_rx("release_rx");

        // Random strobes at mixed rates against an occupancy/timing model
        rx_q.delete();
        exp_q.delete();
        m_cnt = 0; m_rem = 0; m_drop = 0; obs_ovf = 0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 150; c++) begin
                v = ($urandom_range(0, 99) < rates[ph]);
                b = 8'($urandom);
                bus.i_byte   = b;
                bus.i_byte_v = v;
                pop_m = (m_cnt > 0) && (m_rem <= 1);
                acc   = v && ((m_cnt < DEPTH) || pop_m);
                tick();
                if (acc) exp_q.push_back(b);
                if (v && !acc) m_drop++;
                if (bus.o_overflow) obs_ovf++;
                m_cnt = m_cnt + int'(acc) - int'(pop_m);
                m_rem = pop_m ? FRAME : ((m_rem > 0) ? m_rem - 1 : 0);
                chk("rand_full", 32'(bus.o_full), 32'(m_cnt == DEPTH));
            end
        end
        bus.i_byte_v = 1'b0;
        wait_idle("rand_idle");
        check_rx("rand_rx");
        chk("rand_ovf_count", obs_ovf, m_drop);
        chk("framing_errors", rx_frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte slots in the input FIFO (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_byte  input  8  byte from the terminal buffer stage.
REQ-006 SHALL have port i_byte_v  input  1  one-cycle strobe qualifying i_byte; there is no ready signal back to the producer.
REQ-007 SHALL have port o_tx  output  1  serial line out, idle high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port o_full  output  1  high while the FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port o_overflow  output  1  one-cycle pulse when a strobed byte is dropped.

Function
REQ-011 SHALL push i_byte into the FIFO on a rising edge where i_byte_v=1 and the FIFO is not full, or is full but is popped in the same cycle.
REQ-012 SHALL drop the byte and assert o_overflow for exactly one cycle when i_byte_v=1, the FIFO is full, and no pop occurs in that cycle; FIFO contents are unchanged.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: o_tx=1; when the FIFO is non-empty, pop the head into a shift register and go to START.
REQ-015 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: drive 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then go to STOP.
REQ-017 STOP: o_tx=1 for CLKS_PER_BIT cycles; at the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle), else go to IDLE.
REQ-018 o_tx SHALL be registered.
REQ-019 A byte pushed at edge N into an empty FIFO with the block in IDLE SHALL produce o_tx falling at edge N+2.
REQ-020 Each frame SHALL be exactly 10*CLKS_PER_BIT cycles long.
REQ-021 The baud counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and restart at 0 on every state or bit change.
REQ-022 FIFO read/write pointers SHALL carry one extra bit so full and empty are distinguished; the pointers wrap modulo 2*FIFO_DEPTH.
REQ-023 A pop and push in the same cycle on a non-empty FIFO SHALL leave occupancy unchanged.
REQ-024 o_full and o_busy SHALL be combinational from registered state only.

Reset
REQ-025 While rst=0, asynchronously: o_tx=1, o_busy=0, o_full=0, o_overflow=0, state=IDLE, FIFO empty, counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame and raise o_tx immediately; queued bytes are discarded.
REQ-027 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Structure
REQ-028 The state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT SHALL live in the shared package hwterm_pkg.
REQ-029 The FIFO SHALL be a sub-module named byte_fifo (ports clk, rst, push, pop, wdata, rdata, empty, full); the state machine stays in uart_tx.

Verification
REQ-030 CLKS_PER_BIT=4, push 0x41 -> o_tx low at push+2 edges, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high; frame lasts 40 cycles.
REQ-031 Push 0x6A and 0x6B on consecutive cycles -> two frames back-to-back, with the second start bit immediately after the first stop bit.
REQ-032 FIFO_DEPTH=4, 6 pushes on consecutive cycles while idle -> first byte popped, next 4 queued, sixth dropped with a one-cycle o_overflow pulse; 5 frames emitted.
REQ-033 Push while full in the same cycle as the STOP-end pop -> byte accepted, no o_overflow.
REQ-034 Assert rst at bit 3 of a frame with 2 bytes queued -> o_tx=1 asynchronously, o_busy=0, and nothing is transmitted after release.
REQ-035 Random pushes at mixed rates into a UART receiver model -> received sequence equals accepted sequence, and overflow count equals drops.
